// File: rtl/vga_scanout_reader.sv
// vga_scanout_reader: 640x480@60 VGA timing from CLOCK_50 with 4x4-replicated
// scanout of a 160x120 framebuffer, plus a once-per-frame animation tick.
module vga_scanout_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int XSCREEN  = 160
) (
    input  logic        CLOCK_50,
    input  logic        Resetn,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start
);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic        r_phase;
    logic [9:0]  r_hc, r_vc, r_hc_d, r_vc_d;
    logic        w_tick, w_active, w_active_d;
    logic [14:0] w_addr;

    assign w_tick      = r_phase;
    assign w_active    = (r_hc < H_ACT) && (r_vc < V_ACT);
    assign w_active_d  = (r_hc_d < H_ACT) && (r_vc_d < V_ACT);
    assign w_addr      = 15'(r_vc[9:2]) * 15'(XSCREEN) + 15'(r_hc[9:2]);
    assign VGA_CLK     = r_phase;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = w_tick && (r_hc == H_LAST) && (r_vc == V_ACT - 10'd1);

    // The delayed position resets to the last frame position so the first
    // ticks after reset drive blanking rather than a bogus active pixel.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_phase     <= 1'b0;
            r_hc        <= '0;
            r_vc        <= '0;
            r_hc_d      <= H_LAST;
            r_vc_d      <= V_LAST;
            rd_addr     <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else begin
            r_phase <= ~r_phase;
            if (w_tick) begin
                r_hc   <= (r_hc == H_LAST) ? '0 : r_hc + 10'd1;
                if (r_hc == H_LAST)
                    r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 10'd1;
                r_hc_d <= r_hc;
                r_vc_d <= r_vc;
                if (w_active)
                    rd_addr <= w_addr;
                VGA_BLANK_N <= w_active_d;
                VGA_HS      <= ~((r_hc_d >= H_SS) && (r_hc_d < H_SE));
                VGA_VS      <= ~((r_vc_d >= V_SS) && (r_vc_d < V_SE));
                VGA_R       <= {8{w_active_d & rd_data[2]}};
                VGA_G       <= {8{w_active_d & rd_data[1]}};
                VGA_B       <= {8{w_active_d & rd_data[0]}};
            end
        end
    end
endmodule

// File: tb/tb_vga_scanout_reader.sv
// tb_vga_scanout_reader: checks a default-size scanout and a shrunken-geometry
// instance against a tick-index model of the VGA raster.
module tb_vga_scanout_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // instance 0: default geometry; instance 1: small geometry for full frames
    logic        rstn0 = 1'b0, rstn1 = 1'b0;
    logic [14:0] rd_addr0, rd_addr1;
    logic [2:0]  rd_data0, rd_data1;
    logic [7:0]  rr0, gg0, bb0, rr1, gg1, bb1;
    logic        hs0, vs0, bn0, sn0, ck0, fs0;
    logic        hs1, vs1, bn1, sn1, ck1, fs1;

    logic [2:0] mem0 [19200];
    logic [2:0] mem1 [48];

    vga_scanout_reader d0 (
        .CLOCK_50(clk), .Resetn(rstn0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .VGA_R(rr0), .VGA_G(gg0), .VGA_B(bb0), .VGA_HS(hs0), .VGA_VS(vs0),
        .VGA_BLANK_N(bn0), .VGA_SYNC_N(sn0), .VGA_CLK(ck0), .frame_start(fs0)
    );

    vga_scanout_reader #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(3), .XSCREEN(8)
    ) d1 (
        .CLOCK_50(clk), .Resetn(rstn1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .VGA_R(rr1), .VGA_G(gg1), .VGA_B(bb1), .VGA_HS(hs1), .VGA_VS(vs1),
        .VGA_BLANK_N(bn1), .VGA_SYNC_N(sn1), .VGA_CLK(ck1), .frame_start(fs1)
    );

    // framebuffer with one cycle of read latency
    always @(posedge clk) begin
        rd_data0 <= (rd_addr0 < 15'd19200) ? mem0[rd_addr0] : 3'b000;
        rd_data1 <= (rd_addr1 < 15'd48) ? mem1[rd_addr1] : 3'b000;
    end

    // c = cycles since the release edge (0 = first cycle after it), -1 in reset
    int c0 = -1, c1 = -1, gcyc = 0;
    logic started = 1'b0;
    always @(posedge clk) begin
        c0      <= rstn0 ? c0 + 1 : -1;
        c1      <= rstn1 ? c1 + 1 : -1;
        gcyc    <= gcyc + 1;
        started <= 1'b1;
    end

    // Raster model: tick k happens in cycle 2k at position (k%HT, k/HT%VT);
    // the address of tick k is visible from cycle 2k+1, its pixel from 2k+3.
    function automatic logic [44:0] model(input int c, input int which,
        input int ha, input int hf, input int hsw, input int hb,
        input int va, input int vf, input int vsw, input int vb, input int xs);
        int ht, vt, k, h, v, a;
        logic [14:0] addr;
        logic hs, vs, bn, ck, fs;
        logic [2:0] px;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        addr = '0; hs = 1'b1; vs = 1'b1; bn = 1'b0; ck = 1'b0; fs = 1'b0; px = 3'b000;
        if (c >= 0) begin
            ck = (c % 2 == 0);
            k = c / 2; h = k % ht; v = (k / ht) % vt;
            fs = ck && h == ht - 1 && v == va - 1;
            if (c >= 1) begin
                k = (c - 1) / 2; h = k % ht; v = (k / ht) % vt;
                a = (v >= va) ? ((va - 1) / 4) * xs + (ha - 1) / 4
                              : (v / 4) * xs + ((h >= ha) ? ha - 1 : h) / 4;
                addr = 15'(a);
            end
            if (c >= 3) begin
                k = (c - 3) / 2; h = k % ht; v = (k / ht) % vt;
                bn = h < ha && v < va;
                hs = !(h >= ha + hf && h < ha + hf + hsw);
                vs = !(v >= va + vf && v < va + vf + vsw);
                if (bn) px = (which == 0) ? mem0[(v / 4) * xs + h / 4] : mem1[(v / 4) * xs + h / 4];
            end
        end
        return {addr, hs, vs, bn, ck, fs, 1'b0, {8{px[2]}}, {8{px[1]}}, {8{px[0]}}};
    endfunction

    always @(negedge clk) begin
        logic [44:0] e, got;
        if (started) begin
            e   = model(c0, 0, 640, 16, 96, 48, 480, 10, 2, 33, 160);
            got = {rd_addr0, hs0, vs0, bn0, ck0, fs0, sn0, rr0, gg0, bb0};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL d0_pins c=%0d got=%h exp=%h", c0, got, e);
            end
            e   = model(c1, 1, 32, 4, 8, 4, 24, 2, 2, 3, 8);
            got = {rd_addr1, hs1, vs1, bn1, ck1, fs1, sn1, rr1, gg1, bb1};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL d1_pins c=%0d got=%h exp=%h", c1, got, e);
            end
        end
    end

    int hs_fall0 = -1;
    int fs_c[$];
    int fs_t[$];
    always @(negedge clk) begin
        if (started && c0 >= 0 && hs0 === 1'b0 && hs_fall0 < 0) hs_fall0 = c0;
        if (started && fs1 === 1'b1) begin
            fs_c.push_back(c1);
            fs_t.push_back(gcyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic wait_c(input int which, input int t);
        int n = 0;
        while (((which == 0) ? c0 : c1) != t && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk(which == 0 ? "wait_c0" : "wait_c1", (which == 0) ? c0 : c1, t);
    endtask

    task automatic wait_fs(input int cnt, input int bound);
        int n = 0;
        while (fs_t.size() < cnt && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("d1_fs_count", fs_t.size(), cnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 19200; i++) mem0[i] = 3'($urandom);
        for (int i = 0; i < 48; i++) mem1[i] = 3'($urandom);
        mem0[321] = 3'b101;
        mem0[479] = 3'b111;
        fork
            begin
                int cnt;
                repeat (5) @(negedge clk);
                chk("d0_rst_hs", hs0, 1);
                chk("d0_rst_vs", vs0, 1);
                chk("d0_rst_blank", bn0, 0);
                chk("d0_rst_addr", rd_addr0, 0);
                chk("d0_rst_rgb", {rr0, gg0, bb0}, 0);
                rstn0 = 1'b1;
                wait_c(0, 0);
                chk("d0_first_tick", ck0, 1);
                wait_c(0, 1600);
                cnt = 0;
                repeat (1600) begin
                    if (hs0 === 1'b0) cnt++;
                    @(negedge clk);
                end
                chk("d0_hs_low_cycles", cnt, 192);
                chk("d0_hs_fall_c", hs_fall0, 1315);
                wait_c(0, 12809);
                chk("d0_addr_4_8", rd_addr0, 321);
                wait_c(0, 12811);
                chk("d0_rgb_101", {rr0, gg0, bb0}, 24'hFF00FF);
                chk("d0_blank_act", bn0, 1);
                wait_c(0, 14081);
                chk("d0_rgb_639", {rr0, gg0, bb0}, 24'hFFFFFF);
                wait_c(0, 14083);
                chk("d0_rgb_640", {rr0, gg0, bb0}, 0);
                chk("d0_blank_640", bn0, 0);
                chk("d0_addr_hold", rd_addr0, 479);
            end
            begin
                int cnt, base;
                repeat (5) @(negedge clk);
                rstn1 = 1'b1;
                wait_c(1, 2271);
                chk("d1_addr_max", rd_addr1, 47);
                wait_c(1, 2281);
                chk("d1_addr_hold_vblank", rd_addr1, 47);
                wait_fs(2, 7000);
                if (fs_t.size() >= 2) begin
                    chk("d1_fs_first_c", fs_c[0], 2302);
                    chk("d1_fs_period", fs_t[1] - fs_t[0], 2976);
                end
                cnt = 0;
                repeat (2976) begin
                    if (vs1 === 1'b0) cnt++;
                    @(negedge clk);
                end
                chk("d1_vs_low_cycles", cnt, 192);
                wait_c(1, c1 + int'($urandom_range(200, 2200)));
                rstn1 = 1'b0;
                @(negedge clk);
                chk("d1_midrst_hs", hs1, 1);
                chk("d1_midrst_vs", vs1, 1);
                chk("d1_midrst_addr", rd_addr1, 0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                base = fs_t.size();
                rstn1 = 1'b1;
                wait_fs(base + 1, 4000);
                if (fs_t.size() > base) chk("d1_fs_after_rst_c", fs_c[base], 2302);
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
